axby_sequencer: RTL and testbench

//  Computes R = A*X + B*Y on unsigned W-bit operands with one serial shift-add datapath.
//  It is the controlling end of the XY step counter: it drives incxy/cnt_clr and reads the

---
 rtl/axby_pkg.sv | 19 +
 rtl/axby_sequencer_if.sv | 26 ++
 rtl/axby_shift_add.sv | 54 +++++
 rtl/axby_sequencer.sv | 109 ++++++++++
 tb/tb_axby_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/axby_pkg.sv
// Shared constants and FSM encoding for the AXBY serial multiply-accumulate sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axby_pkg;

  localparam int W      = 8;        // operand width; 3-bit step counter gives 8 steps
  localparam int RW     = 2*W + 1;  // result width; 2*255*255 = 130050 fits in 17 bits
  localparam int NSTEPS = 8;        // shift-add steps per product

  // FSM states, kept as plain 3-bit constants for legacy tools
  typedef logic [2:0] axby_state_t;
  localparam axby_state_t S_IDLE   = 3'd0;
  localparam axby_state_t S_LD_AX  = 3'd1;
  localparam axby_state_t S_MUL_AX = 3'd2;
  localparam axby_state_t S_LD_BY  = 3'd3;
  localparam axby_state_t S_MUL_BY = 3'd4;
  localparam axby_state_t S_DONE   = 3'd5;

endpackage

// File: rtl/axby_sequencer_if.sv
// Operand-in / result-out stream bundle of the AXBY sequencer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both streams; slave = sequencer, master = producer/consumer.
//   in_valid/in_ready/in_data  : operand words A, X, B, Y
//   out_valid/out_ready/out_data: result A*X+B*Y
interface axby_sequencer_if;
  import axby_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/axby_shift_add.sv
// Serial shift-add datapath: M (multiplicand), Q (multiplier), acc registers.
// Latency: one step per cycle; loads and clears take effect at the next edge.
// Backpressure: none; the sequencer FSM decides when to load/step/clear.
//   clk, reset (sync, active-low)
//   load_m_i/load_q_i: capture dat_i into M (zero-extended) / Q
//   step_i: acc += Q[0] ? M : 0; M <<= 1; Q >>= 1
//   clr_acc_i: acc <= 0
//   acc_o: accumulator
module axby_shift_add
  import axby_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load_m_i,
  input  logic          load_q_i,
  input  logic          step_i,
  input  logic          clr_acc_i,
  input  logic [W-1:0]  dat_i,
  output logic [RW-1:0] acc_o
);

  logic [RW-1:0] m_q, m_d;
  logic [W-1:0]  q_q, q_d;
  logic [RW-1:0] acc_q, acc_d;

  always_comb begin
    m_d   = m_q;
    q_d   = q_q;
    acc_d = acc_q;
    if (clr_acc_i) acc_d = '0;
    if (load_m_i)  m_d = {{(RW-W){1'b0}}, dat_i};
    if (load_q_i)  q_d = dat_i;
    if (step_i) begin
      if (q_q[0]) acc_d = acc_q + m_q;
      m_d = m_q << 1;
      q_d = q_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
    end else begin
      m_q   <= m_d;
      q_q   <= q_d;
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/axby_sequencer.sv
// Computes A*X + B*Y with one serial shift-add datapath, driving the external XY step counter.
// Latency: Y accepted in cycle t -> counter clear t+1 -> 8 steps t+2..t+9 -> out_valid at t+10.
// Backpressure: in_ready only in load states; result held in DONE until out_ready.
//   clk, reset (sync, active-low)
//   io (slave): operand stream in, result stream out
//   busy, pre_done: status; cnt_2/cnt_6/cnt_7: counter flags in; incxy/cnt_clr: counter control out
module axby_sequencer #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              reset,
  axby_sequencer_if.slave   io,
  output logic              busy,
  output logic              pre_done,
  input  logic              cnt_2,
  input  logic              cnt_6,
  input  logic              cnt_7,
  output logic              incxy,
  output logic              cnt_clr
);
  import axby_pkg::*;

  if (W != 8) begin : g_w_check
    $error("axby_sequencer: W must be 8 to match the 3-bit step counter");
  end

  axby_state_t state_q, state_d;
  logic        sel_q, sel_d;     // 0: next word goes to M, 1: next word goes to Q
  logic        in_ld, in_mul, hs;
  logic        load_m, load_q, step, clr_acc;
  logic [RW-1:0] acc;

  assign in_ld  = (state_q == S_LD_AX) || (state_q == S_LD_BY);
  assign in_mul = (state_q == S_MUL_AX) || (state_q == S_MUL_BY);

  // Once the counter shows 2, both words are in; refuse a third so incxy and
  // cnt_clr can never coincide.
  assign io.in_ready  = in_ld && !cnt_2;
  assign hs           = io.in_ready && io.in_valid;
  assign incxy        = hs || in_mul;
  assign cnt_clr      = (state_q == S_IDLE) || (in_ld && cnt_2);
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign pre_done     = (state_q == S_MUL_BY) && cnt_6;
  assign io.out_valid = (state_q == S_DONE);
  assign io.out_data  = acc;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    load_m  = 1'b0;
    load_q  = 1'b0;
    step    = 1'b0;
    clr_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        clr_acc = 1'b1;
        state_d = S_LD_AX;
      end
      S_LD_AX, S_LD_BY: begin
        if (cnt_2) begin
          sel_d   = 1'b0;
          state_d = (state_q == S_LD_AX) ? S_MUL_AX : S_MUL_BY;
        end else if (hs) begin
          load_m = !sel_q;
          load_q = sel_q;
          sel_d  = !sel_q;
        end
      end
      // The 8th step coincides with cnt_7; the counter wraps to 0 on its own.
      S_MUL_AX: begin
        step = 1'b1;
        if (cnt_7) state_d = S_LD_BY;
      end
      S_MUL_BY: begin
        step = 1'b1;
        if (cnt_7) state_d = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready) begin
          clr_acc = 1'b1;
          state_d = S_LD_AX;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  axby_shift_add u_dp (
    .clk       (clk),
    .reset     (reset),
    .load_m_i  (load_m),
    .load_q_i  (load_q),
    .step_i    (step),
    .clr_acc_i (clr_acc),
    .dat_i     (io.in_data),
    .acc_o     (acc)
  );

endmodule

// File: tb/tb_axby_sequencer.sv
// Bench for axby_sequencer: behavioural XY counter, queue-based result/timing model, directed ops.
// Latency: model expects out_valid 10 cycles after Y and pre_done 2 cycles before out_valid.
// Backpressure: out_ready held low for a chosen number of cycles per op.
`timescale 1ns/1ps
module tb_axby_sequencer;
  import axby_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       busy, pre_done, incxy, cnt_clr;
  logic       cnt_2, cnt_6, cnt_7;
  logic [2:0] cnt = 3'd0;

  axby_sequencer_if bus();

  axby_sequencer #(.W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .io       (bus),
    .busy     (busy),
    .pre_done (pre_done),
    .cnt_2    (cnt_2),
    .cnt_6    (cnt_6),
    .cnt_7    (cnt_7),
    .incxy    (incxy),
    .cnt_clr  (cnt_clr)
  );

  always #5 clk = ~clk;

  // XY step counter: cleared by cnt_clr or system reset, wraps 7->0
  always @(posedge clk) begin
    if (!reset || cnt_clr) cnt <= 3'd0;
    else if (incxy)        cnt <= cnt + 3'd1;
  end
  assign cnt_2 = (cnt == 3'd2);
  assign cnt_6 = (cnt == 3'd6);
  assign cnt_7 = (cnt == 3'd7);

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: collect accepted words; every 4th word yields A*X+B*Y and the
  // cycle numbers at which pre_done and out_valid must appear.
  int   words[$];
  int   exp_res[$];
  int   exp_ov   = -1;
  int   exp_pd   = -1;
  int   exp_mul0 = -1;
  logic rst_prev = 1'b0;
  logic ov_prev  = 1'b0;

  always @(negedge clk) begin
    if (rst_prev) begin
      check("rst_in_ready",  32'(bus.in_ready),  0);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_incxy",     32'(incxy),         0);
      check("rst_busy",      32'(busy),          0);
      check("rst_pre_done",  32'(pre_done),      0);
      check("rst_out_data",  32'(bus.out_data),  0);
      check("rst_cnt_clr",   32'(cnt_clr),       1);
    end
    if (!reset) begin
      words.delete();
      exp_res.delete();
      exp_ov   = -1;
      exp_pd   = -1;
      exp_mul0 = -1;
      ov_prev  = 1'b0;
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      check("incxy_and_cnt_clr", 32'(incxy && cnt_clr), 0);
      if (cyc == exp_mul0) begin
        check("mul_entry_cnt",  32'(cnt),   0);
        check("mul_entry_step", 32'(incxy), 1);
        exp_mul0 = -1;
      end
      if (pre_done || cyc == exp_pd) begin
        check("pre_done_cycle", 32'(pre_done), 32'(cyc == exp_pd));
        if (cyc == exp_pd) exp_pd = -1;
      end
      if ((bus.out_valid && !ov_prev) || cyc == exp_ov) begin
        check("out_valid_onset", 32'(bus.out_valid && !ov_prev), 32'(cyc == exp_ov));
        exp_ov = -1;
      end
      if (bus.out_valid) begin
        check("done_in_ready", 32'(bus.in_ready), 0);
        check("done_busy",     32'(busy),         0);
        check("result_pending", 32'(exp_res.size() > 0), 1);
        if (exp_res.size() > 0) begin
          check("out_data", 32'(bus.out_data), exp_res[0]);
          if (bus.out_ready) void'(exp_res.pop_front());
        end
      end
      ov_prev = bus.out_valid;
      if (bus.in_valid && bus.in_ready) begin
        words.push_back(int'(bus.in_data));
        if (words.size() == 2) exp_mul0 = cyc + 2;
        if (words.size() == 4) begin
          exp_res.push_back(words[0]*words[1] + words[2]*words[3]);
          words.delete();
          exp_mul0 = cyc + 2;
          exp_pd   = cyc + 8;   // counter 6 is the 7th of 8 steps
          exp_ov   = cyc + 10;
        end
      end
    end
  end

  task automatic send(input logic [7:0] w, input int gap);
    logic ok;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", 32'(ok), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(input string name, input int exp, input int hold);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("result_wait", 32'(ok), 1);
    check(name, 32'(bus.out_data), exp);
    repeat (hold) @(negedge clk);
    if (hold > 0) check({name, "_held"}, 32'(bus.out_data), exp);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic op(input string name, input logic [7:0] a, input logic [7:0] x,
                    input logic [7:0] b, input logic [7:0] y,
                    input int gap, input int hold, input int exp);
    send(a, gap);
    send(x, gap);
    send(b, gap);
    send(y, gap);
    get_result(name, exp, hold);
  endtask

  initial begin
    logic ok;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // 1. back-to-back operands
    op("res_3_5_7_2", 8'd3, 8'd5, 8'd7, 8'd2, 0, 0, 29);
    // 2. max values, then zeros to confirm acc is cleared
    op("res_max", 8'd255, 8'd255, 8'd255, 8'd255, 0, 1, 130050);
    op("res_zero", 8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0);
    // 3. input gaps and a stalled consumer
    op("res_gaps", 8'd3, 8'd5, 8'd7, 8'd2, 3, 5, 29);
    op("res_mixed", 8'd200, 8'd1, 8'd16, 8'd17, 1, 2, 472);

    // 4. reset during the 4th MUL_AX step
    send(8'd9, 0);
    send(8'd9, 0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cnt == 3'd2 && incxy && busy && !bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_mul_step3", 32'(ok), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cnt_clr",   32'(cnt_clr),       1);
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_busy",      32'(busy),          0);
    op("res_after_rst", 8'd2, 8'd2, 8'd3, 8'd3, 0, 0, 13);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
